keccak_req_arbiter: RTL and testbench

Round-robin scheduler that shares one `keccak_ctrl` hash core among `N_REQ` requesters. It accepts one 512-bit block plus `hash_num` from the winning requester and sequences the core's `keccak_en`/`devide_en` strobes. It captures the core's 32-bit output words into a local buffer, then streams them back on a shared, back-pressured response bus tagged with the requester id. It sits between the message-block producers and the single `keccak_ctrl` instance.

---
 rtl/keccak_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/keccak_req_arbiter.sv | 118 +++++++++++
 tb/tb_keccak_req_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_arb_pkg.sv
// Shared types and widths for the keccak request arbiter.
package keccak_arb_pkg;

  localparam int BLOCK_W = 512;
  localparam int HNUM_W  = 5;
  localparam int WORD_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    COLLECT,
    SEND
  } state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit scanning ptr, ptr+1, ... mod N.
module rr_arbiter
  import keccak_arb_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = id_w(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id
);

  always_comb begin
    logic           found;
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    // NOTE: every output and temporary gets a value before any branch, so no latch can be inferred.
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IDW + 1)'(k);
      if (sum >= (IDW + 1)'(N)) sum = sum - (IDW + 1)'(N);
      idx = sum[IDW-1:0];
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/keccak_req_arbiter.sv
// Shares one keccak_ctrl core among N_REQ requesters: round-robin accept, start the core,
// buffer its output words, then stream them back tagged with the requester id.
module keccak_req_arbiter
  import keccak_arb_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int OUT_WORDS = 8,
  localparam int IDW       = id_w(N_REQ),
  localparam int CW        = $clog2(OUT_WORDS + 1),
  localparam int AW        = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*BLOCK_W-1:0]   req_data,
  input  logic [N_REQ*HNUM_W-1:0]    req_hash_num,
  output logic [BLOCK_W-1:0]         core_in512,
  output logic [HNUM_W-1:0]          core_hash_num,
  output logic                       core_keccak_en,
  output logic                       core_devide_en,
  input  logic                       core_in_ready,
  input  logic                       core_out_valid,
  input  logic [WORD_W-1:0]          core_hash_out32,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WORD_W-1:0]          rsp_data,
  output logic [IDW-1:0]             rsp_id,
  output logic                       rsp_last,
  output logic                       busy
);

  state_t             state, state_nx;
  logic [IDW-1:0]     ptr, id_q, gnt_id;
  logic [N_REQ-1:0]   gnt;
  logic [BLOCK_W-1:0] data_q;
  logic [HNUM_W-1:0]  hnum_q;
  logic [CW-1:0]      wcnt, rcnt;
  logic [WORD_W-1:0]  word_buf [OUT_WORDS];
  logic               accept, strobe, wcnt_last, rcnt_last, buf_we;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req    (req_valid),
    .ptr    (ptr),
    .en     (state == IDLE && !reset),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready     = gnt;
  assign accept        = |(req_valid & gnt);
  assign wcnt_last     = (wcnt == CW'(OUT_WORDS - 1));
  assign rcnt_last     = (rcnt == CW'(OUT_WORDS - 1));
  assign buf_we        = (state == COLLECT) && core_out_valid;
  assign core_in512    = data_q;
  assign core_hash_num = hnum_q;

  always_comb begin
    state_nx       = state;
    strobe         = 1'b0;
    rsp_valid      = 1'b0;
    rsp_data       = '0;
    rsp_id         = '0;
    rsp_last       = 1'b0;
    case (state)
      IDLE:    if (accept) state_nx = ISSUE;
      ISSUE:   if (core_in_ready) begin
                 strobe   = 1'b1;
                 state_nx = COLLECT;
               end
      COLLECT: if (core_out_valid && wcnt_last) state_nx = SEND;
      SEND: begin
        rsp_valid = 1'b1;
        rsp_data  = word_buf[rcnt[AW-1:0]];
        rsp_id    = id_q;
        rsp_last  = rcnt_last;
        if (rsp_ready && rcnt_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    core_keccak_en = strobe && !reset;
    core_devide_en = strobe && !reset;
    busy           = (state != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= '0;
      id_q   <= '0;
      data_q <= '0;
      hnum_q <= '0;
      wcnt   <= '0;
      rcnt   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        id_q   <= gnt_id;
        data_q <= req_data[gnt_id*BLOCK_W +: BLOCK_W];
        hnum_q <= req_hash_num[gnt_id*HNUM_W +: HNUM_W];
        ptr    <= (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end
      if (strobe) wcnt <= '0;
      if (buf_we) begin
        wcnt <= wcnt + 1'b1;
        if (wcnt_last) rcnt <= '0;
      end
      if (state == SEND && rsp_ready) rcnt <= rcnt + 1'b1;
    end
  end

  // NOTE: the word buffer has no reset; it is always fully rewritten before SEND reads it.
  always_ff @(posedge clk) begin
    if (buf_we) word_buf[wcnt[AW-1:0]] <= core_hash_out32;
  end

endmodule

// File: tb/tb_keccak_req_arbiter.sv
// Self-checking bench: a small core model feeds words, a scoreboard queue holds the expected digest.
module tb_keccak_req_arbiter;
  import keccak_arb_pkg::*;

  localparam int N_REQ     = 4;
  localparam int OUT_WORDS = 8;
  localparam int IDW       = id_w(N_REQ);

  logic                     clk = 1'b0;
  logic                     reset;
  logic [N_REQ-1:0]         req_valid, req_ready;
  logic [N_REQ*BLOCK_W-1:0] req_data;
  logic [N_REQ*HNUM_W-1:0]  req_hash_num;
  logic [BLOCK_W-1:0]       core_in512;
  logic [HNUM_W-1:0]        core_hash_num;
  logic                     core_keccak_en, core_devide_en, core_in_ready, core_out_valid;
  logic [WORD_W-1:0]        core_hash_out32, rsp_data;
  logic                     rsp_valid, rsp_ready, rsp_last, busy;
  logic [IDW-1:0]           rsp_id;

  int vectors     = 0;
  int miscompares = 0;
  logic [WORD_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  keccak_req_arbiter #(.N_REQ(N_REQ), .OUT_WORDS(OUT_WORDS)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_data        (req_data),
    .req_hash_num    (req_hash_num),
    .core_in512      (core_in512),
    .core_hash_num   (core_hash_num),
    .core_keccak_en  (core_keccak_en),
    .core_devide_en  (core_devide_en),
    .core_in_ready   (core_in_ready),
    .core_out_valid  (core_out_valid),
    .core_hash_out32 (core_hash_out32),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .rsp_id          (rsp_id),
    .rsp_last        (rsp_last),
    .busy            (busy)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BLOCK_W-1:0] make_blk(input int seed);
    logic [BLOCK_W-1:0] b;
    for (int j = 0; j < BLOCK_W / 32; j++) b[j*32 +: 32] = {8'(seed), 8'hC3, 16'(j)};
    return b;
  endfunction

  // One full job: grant in IDLE, optional core stall, collect, then drain responses.
  // Returns at the start of the cycle after the last handshake (or mid-COLLECT if abort_words >= 0).
  task automatic do_job(input int id, input int stall, input bit stray, input bit gap,
                        input bit bp, input logic [31:0] base, input bit drop, input int abort_words);
    logic [N_REQ-1:0]   exp_g;
    logic [BLOCK_W-1:0] blk;
    logic [HNUM_W-1:0]  hn;
    logic [31:0]        exp_w, pd;
    logic [IDW-1:0]     pid;
    logic               pl;
    bit                 pstall, done, exp_last;
    int                 guard, w, k;
    blk   = req_data[id*BLOCK_W +: BLOCK_W];
    hn    = req_hash_num[id*HNUM_W +: HNUM_W];
    exp_g = '0;
    exp_g[id] = 1'b1;

    guard = 0;
    @(negedge clk);
    while (req_ready === '0 && guard < 20) begin
      next_cycle();
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (req_ready !== exp_g) begin
      miscompares++;
      $display("FAIL grant: req_ready=%b expected %b", req_ready, exp_g);
      return;
    end
    vectors++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_state: busy=%b rsp_valid=%b expected 0 0", busy, rsp_valid);
    end
    next_cycle();
    if (drop) req_valid[id] = 1'b0;

    for (int s = 0; s < stall; s++) begin
      core_in_ready   = 1'b0;
      core_out_valid  = stray;
      core_hash_out32 = 32'hDEAD_0000 + 32'(s);
      @(negedge clk);
      vectors++;
      if (core_keccak_en !== 1'b0 || req_ready !== '0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL issue_hold: keccak_en=%b req_ready=%b busy=%b expected 0 0 1",
                 core_keccak_en, req_ready, busy);
      end
      next_cycle();
    end
    core_in_ready   = 1'b1;
    core_out_valid  = stray;
    core_hash_out32 = 32'hDEAD_BEEF;
    @(negedge clk);
    vectors++;
    if (core_keccak_en !== 1'b1 || core_devide_en !== 1'b1) begin
      miscompares++;
      $display("FAIL strobe: keccak_en=%b devide_en=%b expected 1 1", core_keccak_en, core_devide_en);
    end
    vectors++;
    if (core_in512 !== blk || core_hash_num !== hn) begin
      miscompares++;
      $display("FAIL core_in: in512[31:0]=%h hash_num=%0d expected %h %0d",
               core_in512[31:0], core_hash_num, blk[31:0], hn);
    end
    next_cycle();

    w = 0;
    k = 0;
    while (w < OUT_WORDS) begin
      if (w == abort_words) return;
      core_out_valid  = gap ? (k % 3 != 1) : 1'b1;
      core_hash_out32 = core_out_valid ? base + 32'(w) : 32'hBAD0_0000 + 32'(k);
      if (core_out_valid) begin
        exp_q.push_back(base + 32'(w));
        w++;
      end
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0 || core_keccak_en !== 1'b0 || busy !== 1'b1 || core_in512 !== blk) begin
        miscompares++;
        $display("FAIL collect: rsp_valid=%b keccak_en=%b busy=%b in512_ok=%b expected 0 0 1 1",
                 rsp_valid, core_keccak_en, busy, core_in512 === blk);
      end
      next_cycle();
      k++;
    end

    core_out_valid  = stray;
    core_hash_out32 = 32'hDEAD_5E4D;
    k      = 0;
    done   = 1'b0;
    pstall = 1'b0;
    pd     = '0;
    pid    = '0;
    pl     = 1'b0;
    while (!done && k < 200) begin
      rsp_ready = bp ? (k % 3 == 0) : 1'b1;
      @(negedge clk);
      if (k == 0) begin
        vectors++;
        if (rsp_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL rsp_latency: rsp_valid=%b expected 1 one cycle after last core word", rsp_valid);
        end
      end
      if (pstall) begin
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_data !== pd || rsp_id !== pid || rsp_last !== pl) begin
          miscompares++;
          $display("FAIL stall_hold: data=%h id=%0d last=%b expected %h %0d %b",
                   rsp_data, rsp_id, rsp_last, pd, pid, pl);
        end
      end
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rsp_extra: unexpected word %h", rsp_data);
          done = 1'b1;
        end else begin
          exp_w    = exp_q.pop_front();
          exp_last = (exp_q.size() == 0);
          if (rsp_data !== exp_w || rsp_id !== IDW'(id) || rsp_last !== exp_last) begin
            miscompares++;
            $display("FAIL rsp_word: data=%h id=%0d last=%b expected %h %0d %b",
                     rsp_data, rsp_id, rsp_last, exp_w, id, exp_last);
          end
          if (exp_last || rsp_last === 1'b1) done = 1'b1;
          else if (busy !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL busy_send: busy=%b expected 1 before last handshake", busy);
          end
        end
      end
      pstall = (rsp_valid === 1'b1) && !rsp_ready;
      pd     = rsp_data;
      pid    = rsp_id;
      pl     = rsp_last;
      next_cycle();
      k++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL rsp_timeout: %0d words outstanding, expected 0", exp_q.size());
    end
    rsp_ready      = 1'b0;
    core_out_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    req_valid       = '1;
    core_in_ready   = 1'b0;
    core_out_valid  = 1'b0;
    core_hash_out32 = '0;
    rsp_ready       = 1'b0;
    next_cycle();
    @(negedge clk);
    vectors++;
    if (req_ready !== '0 || core_keccak_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_grant: req_ready=%b keccak_en=%b expected 0 0", req_ready, core_keccak_en);
    end
    next_cycle();
    reset     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    vectors++;
    if ({busy, rsp_valid, rsp_last, core_keccak_en, core_devide_en} !== 5'b0 || rsp_data !== '0 ||
        rsp_id !== '0 || core_in512 !== '0 || core_hash_num !== '0 || req_ready !== '0) begin
      miscompares++;
      $display("FAIL reset_values: busy=%b rsp_valid=%b rsp_data=%h rsp_id=%0d in512_zero=%b expected all 0",
               busy, rsp_valid, rsp_data, rsp_id, core_in512 === '0);
    end
    next_cycle();
  endtask

  task automatic test_fairness();
    req_valid = '1;
    for (int j = 0; j < 5; j++) do_job(j % N_REQ, 0, 1'b0, 1'b0, 1'b0, 32'h0000_F000 + 32'(j * 16), 1'b0, -1);
  endtask

  task automatic test_single();
    logic [BLOCK_W-1:0] b;
    logic [3:0]         n;
    for (int g = 0; g < BLOCK_W / 16; g++) begin
      n = 4'(g);
      b[(BLOCK_W / 16 - 1 - g)*16 +: 16] = {n, n, n, n};
    end
    req_data[2*BLOCK_W +: BLOCK_W]   = b;
    req_hash_num[2*HNUM_W +: HNUM_W] = 5'd0;
    req_valid = 4'b0100;
    do_job(2, 0, 1'b0, 1'b0, 1'b0, 32'h0000_00A0, 1'b1, -1);
  endtask

  task automatic test_back_pressure();
    req_valid = 4'b0010;
    do_job(1, 0, 1'b0, 1'b0, 1'b1, 32'h0000_B000, 1'b1, -1);
  endtask

  task automatic test_core_stall();
    req_valid = 4'b1000;
    do_job(3, 5, 1'b1, 1'b0, 1'b1, 32'h0000_5000, 1'b1, -1);
  endtask

  task automatic test_gapped();
    req_valid = 4'b0001;
    do_job(0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_6000, 1'b1, -1);
  endtask

  task automatic test_reset_mid_collect();
    req_valid = 4'b0100;
    do_job(2, 0, 1'b0, 1'b0, 1'b0, 32'h0000_C000, 1'b1, 3);
    reset           = 1'b1;
    core_out_valid  = 1'b1;
    core_hash_out32 = 32'hDEAD_0003;
    req_valid       = '1;
    @(negedge clk);
    vectors++;
    if (req_ready !== '0 || core_keccak_en !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_cycle: req_ready=%b keccak_en=%b expected 0 0", req_ready, core_keccak_en);
    end
    next_cycle();
    reset          = 1'b0;
    req_valid      = '0;
    core_out_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, rsp_valid, rsp_last, core_keccak_en, core_devide_en} !== 5'b0 || rsp_data !== '0 ||
        rsp_id !== '0 || core_in512 !== '0 || core_hash_num !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_values: busy=%b rsp_valid=%b rsp_data=%h in512_zero=%b expected all 0",
               busy, rsp_valid, rsp_data, core_in512 === '0);
    end
    exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_quiet: rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy);
      end
    end
    next_cycle();
    req_valid = '1;
    do_job(0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_D000, 1'b1, -1);
    req_valid = '0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL final_idle: busy=%b rsp_valid=%b expected 0 0", busy, rsp_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < N_REQ; i++) begin
      req_data[i*BLOCK_W +: BLOCK_W]   = make_blk(i + 1);
      req_hash_num[i*HNUM_W +: HNUM_W] = HNUM_W'(i * 3 + 1);
    end
    test_reset();
    test_fairness();
    test_single();
    test_back_pressure();
    test_core_stall();
    test_gapped();
    test_reset_mid_collect();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

endmodule
